// File: rtl/store_pkg.sv
// rtl/store_pkg.sv - shared state type, funct3 codes and size helper for the store RMW path
package store_pkg;

  typedef enum logic [2:0] {IDLE, READ, WAIT, WRITE, DONE, ERR} state_t;

  localparam logic [2:0] F3_SB = 3'd0;
  localparam logic [2:0] F3_SH = 3'd1;
  localparam logic [2:0] F3_SW = 3'd2;
  localparam logic [2:0] F3_SD = 3'd3;

  // Access size in bytes; 0 marks an encoding that is never a store.
  function automatic int unsigned size_bytes(input logic [2:0] f3);
    case (f3)
      F3_SB:   return 1;
      F3_SH:   return 2;
      F3_SW:   return 4;
      F3_SD:   return 8;
      default: return 0;
    endcase
  endfunction

endpackage

// File: rtl/store_lane_merge.sv
// rtl/store_lane_merge.sv - merges store data into its byte lanes of a memory word
module store_lane_merge
  import store_pkg::*;
#(
  parameter int XLEN = 64,
  parameter int OFFW = $clog2(XLEN / 8)
) (
  input  logic [XLEN-1:0] rdata,
  input  logic [XLEN-1:0] data,
  input  logic [2:0]      funct3,
  input  logic [OFFW-1:0] off,
  output logic [XLEN-1:0] wdata,
  output logic            misaligned
);

  int unsigned     size;
  logic [XLEN-1:0] mask;

  always_comb begin
    size = size_bytes(funct3);
    mask = '0;
    // Sizes wider than the word are rejected upstream; keep the mask empty for them.
    if (size != 0 && size <= XLEN / 8)
      mask = ({XLEN{1'b1}} >> (XLEN - 8 * size)) << (8 * off);
    wdata      = (rdata & ~mask) | ((data << (8 * off)) & mask);
    misaligned = (size != 0) && ((32'(off) & (size - 1)) != 0);
  end

endmodule

// File: rtl/store_rmw_unit.sv
// rtl/store_rmw_unit.sv - multicycle read-modify-write store engine between control FSM and data memory
module store_rmw_unit
  import store_pkg::*;
#(
  parameter int XLEN       = 64,
  parameter int AW         = 64,
  parameter int RD_LATENCY = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [AW-1:0]   addr,
  input  logic [XLEN-1:0] store_data,
  input  logic [XLEN-1:0] mem_rdata,
  output logic [AW-1:0]   mem_addr,
  output logic            mem_rd,
  output logic            mem_wr,
  output logic [XLEN-1:0] mem_wdata,
  output logic            busy,
  output logic            done,
  output logic            err
);

  localparam int         BYTES    = XLEN / 8;
  localparam int         OFFW     = $clog2(BYTES);
  localparam logic [2:0] CNT_LOAD = 3'(RD_LATENCY - 1);

  state_t          state, next_state;
  logic [2:0]      f3_q;
  logic [AW-1:0]   addr_q;
  logic [XLEN-1:0] data_q;
  logic [2:0]      cnt;

  logic            in_idle, accept, illegal, full_word, misaligned;
  logic [2:0]      sel_f3;
  logic [AW-1:0]   sel_addr;
  logic [XLEN-1:0] merged;

  // In IDLE the live request is checked; afterwards the latched one drives the merge.
  assign in_idle   = (state == IDLE);
  assign accept    = in_idle && start;
  assign sel_f3    = in_idle ? funct3 : f3_q;
  assign sel_addr  = in_idle ? addr : addr_q;
  assign full_word = int'(size_bytes(funct3)) == BYTES;
  assign illegal   = misaligned || size_bytes(funct3) == 0 || int'(size_bytes(funct3)) > BYTES;

  store_lane_merge #(
    .XLEN (XLEN),
    .OFFW (OFFW)
  ) u_merge (
    .rdata      (mem_rdata),
    .data       (data_q),
    .funct3     (sel_f3),
    .off        (sel_addr[OFFW-1:0]),
    .wdata      (merged),
    .misaligned (misaligned)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (start) begin
          if (illegal)        next_state = ERR;
          else if (full_word) next_state = WRITE;
          else                next_state = READ;
        end
      end
      READ:    next_state = WAIT;
      WAIT:    if (cnt == 3'd0) next_state = WRITE;
      WRITE:   next_state = DONE;
      DONE:    next_state = IDLE;
      ERR:     next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Outputs are registered from next_state so they line up with the state they describe.
  always_ff @(posedge clk) begin
    if (reset) begin
      f3_q      <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      cnt       <= '0;
      mem_addr  <= '0;
      mem_rd    <= 1'b0;
      mem_wr    <= 1'b0;
      mem_wdata <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      if (accept) begin
        f3_q   <= funct3;
        addr_q <= addr;
        data_q <= store_data;
      end
      if (state == READ)                   cnt <= CNT_LOAD;
      else if (state == WAIT && cnt != 0)  cnt <= cnt - 3'd1;

      if (accept && !illegal && full_word) mem_wdata <= store_data;
      else if (state == WAIT && cnt == 0)  mem_wdata <= merged;

      mem_rd   <= (next_state == READ);
      mem_wr   <= (next_state == WRITE);
      busy     <= (next_state != IDLE);
      done     <= (next_state == DONE);
      err      <= (next_state == ERR);
      mem_addr <= (next_state inside {READ, WAIT, WRITE})
                  ? {sel_addr[AW-1:OFFW], {OFFW{1'b0}}} : '0;
    end
  end

endmodule

// File: tb/tb_store_rmw_unit.sv
// tb/tb_store_rmw_unit.sv - scoreboard bench for store_rmw_unit at read latencies 1 and 3
module tb_store_rmw_unit;
  import store_pkg::*;

  localparam int EV_RD = 0, EV_WR = 1, EV_DONE = 2, EV_ERR = 3;

  typedef struct {
    int          kind;
    int          cyc;
    logic [63:0] addr;
    logic [63:0] data;
  } ev_t;

  logic        clk = 1'b0, reset = 1'b1, start = 1'b0;
  logic [2:0]  funct3 = '0;
  logic [63:0] addr = '0, store_data = '0, mem_rdata0 = '0, mem_rdata1 = '0;
  logic [63:0] mem_addr0, mem_wdata0, mem_addr1, mem_wdata1;
  logic        mem_rd0, mem_wr0, busy0, done0, err0;
  logic        mem_rd1, mem_wr1, busy1, done1, err1;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  store_rmw_unit #(.XLEN(64), .AW(64), .RD_LATENCY(1)) u_dut0 (
    .clk(clk), .reset(reset), .start(start), .funct3(funct3), .addr(addr),
    .store_data(store_data), .mem_rdata(mem_rdata0), .mem_addr(mem_addr0),
    .mem_rd(mem_rd0), .mem_wr(mem_wr0), .mem_wdata(mem_wdata0),
    .busy(busy0), .done(done0), .err(err0));

  store_rmw_unit #(.XLEN(64), .AW(64), .RD_LATENCY(3)) u_dut1 (
    .clk(clk), .reset(reset), .start(start), .funct3(funct3), .addr(addr),
    .store_data(store_data), .mem_rdata(mem_rdata1), .mem_addr(mem_addr1),
    .mem_rd(mem_rd1), .mem_wr(mem_wr1), .mem_wdata(mem_wdata1),
    .busy(busy1), .done(done1), .err(err1));

  ev_t         q0[$], q1[$];
  logic [63:0] ref_mem[logic [63:0]];
  logic [63:0] phys0[logic [63:0]], phys1[logic [63:0]];
  int          rdy_cyc[2] = '{-1, -1};
  logic [63:0] rdy_addr[2];
  int          vectors = 0, miscompares = 0;
  bit          mon_en = 1'b0;

  function automatic logic [63:0] init_word(input logic [63:0] a);
    return a * 64'h9E37_79B9_7F4A_7C15 + 64'h0123_4567_89AB_CDEF;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int id, input ev_t e);
    if (id == 0) q0.push_back(e);
    else         q1.push_back(e);
  endtask

  // Compares every strobe the DUT raises against the oldest expected event,
  // then plays memory: rdata is valid only on the cycle RD_LATENCY after mem_rd.
  task automatic mon(input int id, input logic rd, wr, dn, er, bsy,
                     input logic [63:0] ma, wd, output logic [63:0] rdata);
    logic [3:0] fired;
    ev_t        e;
    int         rl;
    rl    = (id == 0) ? 1 : 3;
    fired = {er, dn, wr, rd};
    if (rd || wr) check($sformatf("dut%0d rd_wr_exclusive", id), 64'(rd & wr), 64'h0);
    if (!bsy) check($sformatf("dut%0d idle_mem_addr", id), ma, 64'h0);
    for (int k = 0; k < 4; k++) begin
      if (fired[k]) begin
        if ((id == 0 ? q0.size() : q1.size()) == 0) begin
          check($sformatf("dut%0d unexpected_event", id), 64'(k), 64'hFF);
        end else begin
          e = (id == 0) ? q0.pop_front() : q1.pop_front();
          check($sformatf("dut%0d event_kind", id), 64'(k), 64'(e.kind));
          check($sformatf("dut%0d event_cycle kind%0d", id, k), 64'(cyc), 64'(e.cyc));
          if (k == EV_RD || k == EV_WR) check($sformatf("dut%0d mem_addr kind%0d", id, k), ma, e.addr);
          if (k == EV_WR) check($sformatf("dut%0d mem_wdata", id), wd, e.data);
        end
      end
    end
    if (rd) begin
      rdy_cyc[id]  = cyc + rl;
      rdy_addr[id] = ma;
    end
    if (wr) begin
      if (id == 0) phys0[ma] = wd;
      else         phys1[ma] = wd;
    end
    if (cyc == rdy_cyc[id]) begin
      if (id == 0) rdata = phys0.exists(rdy_addr[0]) ? phys0[rdy_addr[0]] : init_word(rdy_addr[0]);
      else         rdata = phys1.exists(rdy_addr[1]) ? phys1[rdy_addr[1]] : init_word(rdy_addr[1]);
    end else begin
      rdata = {$urandom, $urandom};
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      mon(0, mem_rd0, mem_wr0, done0, err0, busy0, mem_addr0, mem_wdata0, mem_rdata0);
      mon(1, mem_rd1, mem_wr1, done1, err1, busy1, mem_addr1, mem_wdata1, mem_rdata1);
    end
  end

  // Issues one store to both DUTs and schedules the expected memory traffic.
  // poke: extra starts while busy / in DONE that must be ignored.
  // rst_wait: reset lands while both DUTs wait for read data.
  task automatic issue(input logic [2:0] f3, input logic [63:0] a, input logic [63:0] d,
                       input bit poke, input bit rst_wait);
    int          s, sz, off, lat, rl;
    bit          ill, full;
    logic [63:0] al, w;
    s    = cyc;
    sz   = (f3 < 4) ? (1 << f3) : 0;
    off  = int'(a % 8);
    ill  = (sz == 0) ? 1'b1 : ((off % sz) != 0);
    full = (sz == 8);
    al   = a - 64'(off);
    w    = ref_mem.exists(al) ? ref_mem[al] : init_word(al);
    if (!ill)
      for (int i = 0; i < sz; i++) w[8 * (off + i) +: 8] = d[8 * i +: 8];
    for (int id = 0; id < 2; id++) begin
      rl = (id == 0) ? 1 : 3;
      if (ill) begin
        push(id, '{EV_ERR, s + 1, 64'h0, 64'h0});
      end else if (full) begin
        push(id, '{EV_WR, s + 1, al, w});
        push(id, '{EV_DONE, s + 2, 64'h0, 64'h0});
      end else begin
        push(id, '{EV_RD, s + 1, al, 64'h0});
        if (!rst_wait) begin
          push(id, '{EV_WR, s + rl + 2, al, w});
          push(id, '{EV_DONE, s + rl + 3, 64'h0, 64'h0});
        end
      end
    end
    if (!ill && !rst_wait) ref_mem[al] = w;
    lat        = ill ? 1 : (full ? 2 : 6);
    funct3     = f3;
    addr       = a;
    store_data = d;
    start      = 1'b1;
    for (int k = 1; k <= lat; k++) begin
      @(negedge clk);
      start = poke && (k == 2 || k == 4);
      if (start) begin
        funct3     = F3_SD;
        addr       = 64'h80;
        store_data = {$urandom, $urandom};
      end
      reset = rst_wait && (k == 2);
      if (rst_wait && k == 3) begin
        check("dut0 busy_after_reset", 64'(busy0), 64'h0);
        check("dut1 busy_after_reset", 64'(busy1), 64'h0);
      end
    end
    @(negedge clk);
  endtask

  initial begin
    logic [2:0]  rf3;
    logic [63:0] ra;
    int          rsz;
    repeat (3) @(negedge clk);
    check("dut0 reset_outputs", {mem_addr0 | mem_wdata0, 59'h0, mem_rd0, mem_wr0, busy0, done0, err0}, 64'h0);
    check("dut1 reset_outputs", {mem_addr1 | mem_wdata1, 59'h0, mem_rd1, mem_wr1, busy1, done1, err1}, 64'h0);
    reset  = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);

    ref_mem[64'h1000] = 64'h1122_3344_5566_7788;
    phys0[64'h1000]   = 64'h1122_3344_5566_7788;
    phys1[64'h1000]   = 64'h1122_3344_5566_7788;
    ref_mem[64'h2000] = 64'h0;
    phys0[64'h2000]   = 64'h0;
    phys1[64'h2000]   = 64'h0;

    issue(F3_SB, 64'h1005, 64'hFF, 1'b0, 1'b0);
    issue(F3_SH, 64'h2006, 64'hFFFF_FFFF_FFFF_8001, 1'b0, 1'b0);
    issue(F3_SD, 64'h3000, 64'hDEAD_BEEF_CAFE_F00D, 1'b0, 1'b0);
    issue(F3_SW, 64'h4002, 64'h1234_5678, 1'b0, 1'b0);
    issue(3'd5, 64'h4000, 64'h55, 1'b0, 1'b0);
    issue(F3_SB, 64'h7, 64'hAB, 1'b1, 1'b0);
    issue(F3_SB, 64'h11, 64'h5A, 1'b0, 1'b1);
    issue(F3_SB, 64'h11, 64'hC3, 1'b0, 1'b0);

    for (int n = 0; n < 60; n++) begin
      rf3 = ($urandom_range(0, 9) < 8) ? 3'($urandom_range(0, 3)) : 3'($urandom_range(4, 7));
      ra  = 64'($urandom_range(0, 255));
      rsz = (rf3 < 4) ? (1 << rf3) : 1;
      if ($urandom_range(0, 3) != 0) ra = ra - (ra % 64'(rsz));
      issue(rf3, ra, {$urandom, $urandom}, ($urandom_range(0, 3) == 0), 1'b0);
    end

    repeat (4) @(negedge clk);
    check("dut0 pending_events", 64'(q0.size()), 64'h0);
    check("dut1 pending_events", 64'(q1.size()), 64'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
